// File: rtl/memory_fill_arbiter_if.sv
// rtl/memory_fill_arbiter_if.sv - Cache miss, store, main-memory and fill-port signal bundle
interface memory_fill_arbiter_if;
  logic        icache_miss;
  logic [15:0] icache_miss_addr;
  logic        dcache_miss;
  logic [15:0] dcache_miss_addr;
  logic        dcache_write;
  logic [15:0] dcache_write_addr;
  logic [15:0] dcache_write_data;
  logic        mem_enable;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_data_out;
  logic        mem_data_valid;
  logic [15:0] mem_data_in;
  logic [15:0] fill_data;
  logic [2:0]  fill_word;
  logic        fill_we_i;
  logic        fill_we_d;
  logic        tag_we_i;
  logic        tag_we_d;
  logic        pipe_stall;

  modport master (
    output icache_miss, icache_miss_addr, dcache_miss, dcache_miss_addr,
    output dcache_write, dcache_write_addr, dcache_write_data,
    output mem_data_valid, mem_data_in,
    input  mem_enable, mem_wr, mem_addr, mem_data_out,
    input  fill_data, fill_word, fill_we_i, fill_we_d, tag_we_i, tag_we_d, pipe_stall
  );

  modport slave (
    input  icache_miss, icache_miss_addr, dcache_miss, dcache_miss_addr,
    input  dcache_write, dcache_write_addr, dcache_write_data,
    input  mem_data_valid, mem_data_in,
    output mem_enable, mem_wr, mem_addr, mem_data_out,
    output fill_data, fill_word, fill_we_i, fill_we_d, tag_we_i, tag_we_d, pipe_stall
  );
endinterface

// File: rtl/memory_fill_arbiter.sv
// rtl/memory_fill_arbiter.sv - Shared main-memory arbiter: 8-word I/D cache line fills and write-through stores
module memory_fill_arbiter (
  input logic                  clk,
  input logic                  rst,
  memory_fill_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, FILL_D = 2'd1, FILL_I = 2'd2} state_t;

  state_t      state, state_next;
  logic [15:0] base, base_next;
  logic [3:0]  issue_cnt, issue_next;
  logic [2:0]  recv_cnt, recv_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      base      <= '0;
      issue_cnt <= '0;
      recv_cnt  <= '0;
    end else begin
      state     <= state_next;
      base      <= base_next;
      issue_cnt <= issue_next;
      recv_cnt  <= recv_next;
    end
  end

  always_comb begin
    state_next       = state;
    base_next        = base;
    issue_next       = issue_cnt;
    recv_next        = recv_cnt;
    bus.mem_enable   = 1'b0;
    bus.mem_wr       = 1'b0;
    bus.mem_addr     = '0;
    bus.mem_data_out = '0;
    bus.fill_data    = '0;
    bus.fill_word    = '0;
    bus.fill_we_i    = 1'b0;
    bus.fill_we_d    = 1'b0;
    bus.tag_we_i     = 1'b0;
    bus.tag_we_d     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.dcache_miss) begin
          state_next = FILL_D;
          base_next  = bus.dcache_miss_addr & 16'hFFF0;
          issue_next = '0;
          recv_next  = '0;
        end else if (bus.icache_miss) begin
          state_next = FILL_I;
          base_next  = bus.icache_miss_addr & 16'hFFF0;
          issue_next = '0;
          recv_next  = '0;
        end else if (bus.dcache_write) begin
          bus.mem_enable   = 1'b1;
          bus.mem_wr       = 1'b1;
          bus.mem_addr     = bus.dcache_write_addr;
          bus.mem_data_out = bus.dcache_write_data;
        end
      end
      FILL_D, FILL_I: begin
        if (issue_cnt < 4'd8) begin
          bus.mem_enable = 1'b1;
          bus.mem_addr   = base + {12'd0, issue_cnt[2:0], 1'b0};
          issue_next     = issue_cnt + 4'd1;
        end
        // Completion is purely the count of returns, so any memory latency works.
        if (bus.mem_data_valid) begin
          bus.fill_data = bus.mem_data_in;
          bus.fill_word = recv_cnt;
          bus.fill_we_d = (state == FILL_D);
          bus.fill_we_i = (state == FILL_I);
          recv_next     = recv_cnt + 3'd1;
          if (recv_cnt == 3'd7) begin
            bus.tag_we_d = (state == FILL_D);
            bus.tag_we_i = (state == FILL_I);
            state_next   = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    if (rst) begin
      bus.mem_enable   = 1'b0;
      bus.mem_wr       = 1'b0;
      bus.mem_addr     = '0;
      bus.mem_data_out = '0;
      bus.fill_data    = '0;
      bus.fill_word    = '0;
      bus.fill_we_i    = 1'b0;
      bus.fill_we_d    = 1'b0;
      bus.tag_we_i     = 1'b0;
      bus.tag_we_d     = 1'b0;
    end
  end

  assign bus.pipe_stall = bus.icache_miss | bus.dcache_miss | (state != IDLE);
endmodule
